// File: rtl/hps_pixel_writer.sv
// HPS-to-SDRAM pixel writer: toggle req/ack PIO handshake, pixel FIFO, packing
// into 16-bit frame-buffer words, and X/Y/frame tracking for one write port.
module hps_pixel_writer #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 8,
    parameter int PIX_W      = 10
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iSTART,
    input  logic             iREQ_TOGGLE,
    input  logic [PIX_W-1:0] iPIX_DATA,
    output logic             oACK_TOGGLE,
    input  logic             iWR_READY,
    output logic             oWR,
    output logic [15:0]      oWR_DATA,
    output logic             oWR_LOAD,
    output logic [15:0]      oX_Cont,
    output logic [15:0]      oY_Cont,
    output logic             oFrame_Done,
    output logic [15:0]      oFrame_Cont,
    output logic             oABORT,
    output logic             oBUSY
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state;
    logic             req_s1, req_s2, req_s3;
    logic             st_s1, st_s2, st_s3;
    logic             pend;
    logic [PIX_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;

    logic             req_edge, start_rise, req_now;
    logic             fifo_empty, fifo_full;
    logic             abort, push, pop, last_pix;
    logic [PIX_W-1:0] rd_pix;

    always_comb begin
        req_edge   = req_s2 ^ req_s3;
        start_rise = st_s2 & ~st_s3;
        req_now    = req_edge | pend;
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        abort      = (state == RUN) && !st_s2;
        push       = (state == RUN) && !abort && req_now && !fifo_full;
        pop        = (state == RUN) && !abort && !fifo_empty && iWR_READY;
        last_pix   = (oX_Cont == 16'(H_ACTIVE - 1)) && (oY_Cont == 16'(V_ACTIVE - 1));
        rd_pix     = mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge iCLK) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= iPIX_DATA;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state       <= IDLE;
            req_s1      <= 1'b0;
            req_s2      <= 1'b0;
            req_s3      <= 1'b0;
            st_s1       <= 1'b0;
            st_s2       <= 1'b0;
            st_s3       <= 1'b0;
            pend        <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            oACK_TOGGLE <= 1'b0;
            oWR         <= 1'b0;
            oWR_DATA    <= '0;
            oWR_LOAD    <= 1'b0;
            oX_Cont     <= '0;
            oY_Cont     <= '0;
            oFrame_Done <= 1'b0;
            oFrame_Cont <= '0;
            oABORT      <= 1'b0;
            oBUSY       <= 1'b0;
        end else begin
            req_s1      <= iREQ_TOGGLE;
            req_s2      <= req_s1;
            req_s3      <= req_s2;
            st_s1       <= iSTART;
            st_s2       <= st_s1;
            st_s3       <= st_s2;
            oWR         <= 1'b0;
            oWR_LOAD    <= 1'b0;
            oFrame_Done <= 1'b0;

            // Outside RUN every request is acked without a push; in RUN a
            // blocked request (FIFO full or abort cycle) stays pending.
            if (push || (req_now && state != RUN)) begin
                oACK_TOGGLE <= ~oACK_TOGGLE;
                pend        <= 1'b0;
            end else if (req_now) begin
                pend <= 1'b1;
            end

            if (push)
                wr_ptr <= wr_ptr + 1'b1;

            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                oWR      <= 1'b1;
                oWR_DATA <= {1'b0, rd_pix[PIX_W-1 -: 5], rd_pix[PIX_W-1 -: 10]};
                if (!last_pix) begin
                    if (oX_Cont == 16'(H_ACTIVE - 1)) begin
                        oX_Cont <= '0;
                        oY_Cont <= oY_Cont + 16'd1;
                    end else begin
                        oX_Cont <= oX_Cont + 16'd1;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (start_rise) begin
                        state    <= LOAD;
                        oWR_LOAD <= 1'b1;
                        oBUSY    <= 1'b1;
                        oABORT   <= 1'b0;
                        wr_ptr   <= '0;
                        rd_ptr   <= '0;
                        oX_Cont  <= '0;
                        oY_Cont  <= '0;
                    end
                end
                LOAD: state <= RUN;
                RUN: begin
                    if (abort) begin
                        state  <= IDLE;
                        oBUSY  <= 1'b0;
                        oABORT <= 1'b1;
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                    end else if (pop && last_pix) begin
                        state       <= DONE;
                        oBUSY       <= 1'b0;
                        oFrame_Done <= 1'b1;
                        oFrame_Cont <= oFrame_Cont + 16'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hps_pixel_writer.sv
// Directed-sequence bench for hps_pixel_writer with random pixel data and a
// queue-based reference of the words expected on the SDRAM write port.
module tb_hps_pixel_writer;

    localparam int H = 8;
    localparam int V = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        req = 1'b0;
    logic [9:0]  pix = '0;
    logic        ready = 1'b0;

    logic        oACK_TOGGLE, oWR, oWR_LOAD, oFrame_Done, oABORT, oBUSY;
    logic [15:0] oWR_DATA, oX_Cont, oY_Cont, oFrame_Cont;

    int          vectors = 0;
    int          miscompares = 0;
    int          ready_mode = 0;
    int          done_cnt = 0;
    int          load_cnt = 0;
    logic [15:0] cap_q[$];
    logic [15:0] exp_q[$];

    hps_pixel_writer #(
        .H_ACTIVE  (H),
        .V_ACTIVE  (V),
        .FIFO_DEPTH(DEPTH),
        .PIX_W     (10)
    ) dut (
        .iCLK       (clk),
        .iRST       (rst),
        .iSTART     (start),
        .iREQ_TOGGLE(req),
        .iPIX_DATA  (pix),
        .oACK_TOGGLE(oACK_TOGGLE),
        .iWR_READY  (ready),
        .oWR        (oWR),
        .oWR_DATA   (oWR_DATA),
        .oWR_LOAD   (oWR_LOAD),
        .oX_Cont    (oX_Cont),
        .oY_Cont    (oY_Cont),
        .oFrame_Done(oFrame_Done),
        .oFrame_Cont(oFrame_Cont),
        .oABORT     (oABORT),
        .oBUSY      (oBUSY)
    );

    always #5 clk = ~clk;

    // Write-port monitor and iWR_READY driver (0 = low, 1 = high, else random).
    always @(negedge clk) begin
        if (oWR === 1'b1) cap_q.push_back(oWR_DATA);
        if (oFrame_Done === 1'b1) done_cnt++;
        if (oWR_LOAD === 1'b1) load_cnt++;
        case (ready_mode)
            0:       ready = 1'b0;
            1:       ready = 1'b1;
            default: ready = ($urandom_range(3) != 0);
        endcase
    end

    function automatic logic [15:0] pack(input int p);
        return 16'(((p / 32) * 1024) + p);
    endfunction

    // Expected {X, Y} after n writes of a frame: row-major, held at the last pixel.
    function automatic logic [31:0] xy_model(input int n);
        if (n >= H * V) return {16'(H - 1), 16'(V - 1)};
        return {16'(n % H), 16'(n / H)};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [9:0] v, input int bound, output bit acked);
        pix = v;
        req = ~req;
        acked = 1'b0;
        for (int i = 0; i < bound && !acked; i++) begin
            step(1);
            if (oACK_TOGGLE === req) acked = 1'b1;
        end
    endtask

    task automatic wait_caps(input int n, input int bound);
        for (int i = 0; i < bound && cap_q.size() < n; i++) step(1);
    endtask

    task automatic cmp_caps(input string tag);
        int n;
        check({tag, "_count"}, 64'(cap_q.size()), 64'(exp_q.size()));
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check(tag, 64'(cap_q[i]), 64'(exp_q[i]));
    endtask

    initial begin
        bit         ok;
        logic [9:0] v;

        // Reset state
        rst = 1'b1;
        step(3);
        check("reset_ctrl", {oACK_TOGGLE, oWR, oWR_LOAD, oFrame_Done, oABORT, oBUSY}, '0);
        check("reset_data", {oWR_DATA, oX_Cont, oY_Cont, oFrame_Cont}, '0);
        rst = 1'b0;
        step(2);

        // Arm: LOAD pulse 3 cycles after the start edge
        start = 1'b1;
        step(2);
        check("load_early", oWR_LOAD, 0);
        step(1);
        check("load_pulse", oWR_LOAD, 1);
        check("busy_load", oBUSY, 1);
        step(1);
        check("load_single", oWR_LOAD, 0);
        check("xy_after_load", {oX_Cont, oY_Cont}, 0);
        check("load_count", load_cnt, 1);

        // First pixel: ack at +3, strobe one cycle later
        ready_mode = 1;
        step(1);
        pix = 10'h3FF;
        req = ~req;
        exp_q.push_back(pack(10'h3FF));
        step(2);
        check("ack_not_yet", oACK_TOGGLE, 0);
        step(1);
        check("ack_3cyc", oACK_TOGGLE, 1);
        check("wr_not_yet", oWR, 0);
        step(1);
        check("wr_strobe", oWR, 1);
        check("wr_data_7fff", oWR_DATA, 16'h7FFF);
        check("xy_after_1", {oX_Cont, oY_Cont}, xy_model(1));

        // Backpressure: eight fill the buffer, ninth ack withheld until drain
        ready_mode = 0;
        step(2);
        for (int i = 0; i < DEPTH; i++) begin
            v = 10'($urandom_range(1023));
            exp_q.push_back(pack(v));
            send(v, 10, ok);
            check("bp_ack", ok, 1);
        end
        v = 10'($urandom_range(1023));
        exp_q.push_back(pack(v));
        send(v, 20, ok);
        check("bp_ack_withheld", ok, 0);
        check("bp_no_write", 64'(cap_q.size()), 1);
        ready_mode = 1;
        for (int i = 0; i < 20 && oACK_TOGGLE !== req; i++) step(1);
        check("bp_ack_after_ready", oACK_TOGGLE, req);
        wait_caps(10, 40);
        cmp_caps("bp_order");
        check("xy_after_10", {oX_Cont, oY_Cont}, xy_model(10));

        // Rest of the frame with random write-port backpressure
        ready_mode = 2;
        for (int n = 10; n < H * V; n++) begin
            v = 10'($urandom_range(1023));
            exp_q.push_back(pack(v));
            send(v, 60, ok);
            check("frame_ack", ok, 1);
        end
        wait_caps(H * V, 200);
        step(6);
        cmp_caps("frame_data");
        check("frame_done_pulses", done_cnt, 1);
        check("frame_cont", oFrame_Cont, 1);
        check("xy_frame_end", {oX_Cont, oY_Cont}, xy_model(H * V));
        check("busy_after_frame", oBUSY, 0);

        // Beyond the frame: acked, never written
        ready_mode = 1;
        send(10'($urandom_range(1023)), 10, ok);
        check("idle_discard_ack", ok, 1);
        step(5);
        check("idle_no_write", 64'(cap_q.size()), 64'(H * V));

        // Abort with a full buffer and a pending request
        start = 1'b0;
        step(4);
        start = 1'b1;
        for (int i = 0; i < 10 && load_cnt < 2; i++) step(1);
        step(2);
        check("rearm_load", load_cnt, 2);
        check("rearm_xy", {oX_Cont, oY_Cont}, 0);
        cap_q.delete();
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            v = 10'($urandom_range(1023));
            exp_q.push_back(pack(v));
            send(v, 10, ok);
        end
        wait_caps(5, 20);
        ready_mode = 0;
        step(1);
        for (int i = 0; i < DEPTH; i++) begin
            send(10'($urandom_range(1023)), 10, ok);
            check("abort_fill_ack", ok, 1);
        end
        send(10'($urandom_range(1023)), 12, ok);
        check("abort_pending_withheld", ok, 0);
        start = 1'b0;
        for (int i = 0; i < 10 && oACK_TOGGLE !== req; i++) step(1);
        check("abort_pending_acked", oACK_TOGGLE, req);
        step(2);
        check("abort_flag", oABORT, 1);
        check("abort_busy", oBUSY, 0);
        ready_mode = 1;
        step(10);
        send(10'($urandom_range(1023)), 10, ok);
        check("abort_idle_ack", ok, 1);
        step(6);
        cmp_caps("abort_flushed");
        check("abort_no_done", done_cnt, 1);
        check("abort_xy_hold", {oX_Cont, oY_Cont}, xy_model(5));

        // Asynchronous reset mid-run with a half-full buffer
        step(2);
        start = 1'b1;
        for (int i = 0; i < 10 && load_cnt < 3; i++) step(1);
        step(2);
        check("load_clears_abort", oABORT, 0);
        ready_mode = 0;
        step(1);
        for (int i = 0; i < DEPTH / 2; i++) begin
            send(10'($urandom_range(1023)), 10, ok);
            check("rst_fill_ack", ok, 1);
        end
        #1 rst = 1'b1;
        #1;
        check("async_rst_ctrl", {oACK_TOGGLE, oWR, oWR_LOAD, oFrame_Done, oABORT, oBUSY}, '0);
        check("async_rst_data", {oWR_DATA, oX_Cont, oY_Cont, oFrame_Cont}, '0);
        req = 1'b0;
        start = 1'b0;
        step(3);
        rst = 1'b0;
        step(2);
        start = 1'b1;
        for (int i = 0; i < 10 && load_cnt < 4; i++) step(1);
        step(2);
        check("post_rst_load", load_cnt, 4);
        check("post_rst_state", {oABORT, oBUSY, oX_Cont, oY_Cont}, {1'b0, 1'b1, 32'h0});
        cap_q.delete();
        exp_q.delete();
        ready_mode = 1;
        v = 10'($urandom_range(1023));
        exp_q.push_back(pack(v));
        send(v, 10, ok);
        check("post_rst_ack", ok, 1);
        wait_caps(1, 10);
        step(3);
        cmp_caps("post_rst_clean");
        check("post_rst_xy", {oX_Cont, oY_Cont}, xy_model(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hps_pixel_writer.md
Name: hps_pixel_writer

Overview:
- Reverse path of the camera frame-buffer datapath: the HPS pushes grayscale pixels one at a time over PIO using a toggle req/ack handshake.
- The block buffers the pixels, packs them into the 16-bit frame-buffer word format, and issues write strobes to one SDRAM controller write port.
- It tracks X/Y position across one frame of H_ACTIVE x V_ACTIVE pixels and reports frame completion back to the HPS.

Parameters:
- H_ACTIVE, 640, pixels per line.
- V_ACTIVE, 480, lines per frame.
- FIFO_DEPTH, 8, pixel buffer entries (power of 2, >=2).
- PIX_W, 10, grayscale pixel width.

Ports:
- iCLK  in  1  block clock (sdram/vga domain).
- iRST  in  1  asynchronous active-high reset.
- iSTART  in  1  HPS PIO level; rising edge arms a frame, low aborts.
- iREQ_TOGGLE  in  1  HPS PIO; each toggle offers one pixel (asynchronous to iCLK).
- iPIX_DATA  in  PIX_W  HPS PIO pixel; stable from before the toggle until the ack.
- oACK_TOGGLE  out  1  toggles once per accepted or discarded pixel.
- iWR_READY  in  1  SDRAM write FIFO can take a word this cycle.
- oWR  out  1  one-cycle write strobe.
- oWR_DATA  out  16  packed word {1'b0, pix[9:5], pix[9:0]}.
- oWR_LOAD  out  1  one-cycle write-address reload pulse.
- oX_Cont  out  16  column of the next pixel to be written.
- oY_Cont  out  16  line of the next pixel to be written.
- oFrame_Done  out  1  one-cycle pulse after the last pixel of a frame is written.
- oFrame_Cont  out  16  completed frames, wraps at 16'hFFFF->0.
- oABORT  out  1  sticky; set on abort, cleared on next LOAD.
- oBUSY  out  1  high in LOAD or RUN.

Behaviour:
- Reset (async, iRST=1): all outputs 0, FSM=IDLE, FIFO empty, sync flops 0.
- Sync: iREQ_TOGGLE and iSTART each go through a 2-flop synchronizer.
  - Req edge = sync2 XOR sync3 (third flop).
  - Start rise = sync2 & ~sync3.
- States:
  - IDLE: start rise -> LOAD.
  - LOAD: one cycle. oWR_LOAD=1, FIFO flushed, X/Y cleared, oABORT cleared -> RUN.
  - RUN: accept pixels and drain the FIFO. Transitions to DONE when the pixel at X=H_ACTIVE-1, Y=V_ACTIVE-1 is strobed. Synced iSTART=0 -> IDLE, flush FIFO, set oABORT, no oFrame_Done.
  - DONE: one cycle. oFrame_Done=1, oFrame_Cont+1 -> IDLE. A new frame requires iSTART low then high again.
- Accept, in RUN:
  - On req edge with FIFO not full: push iPIX_DATA and toggle oACK_TOGGLE in the same cycle.
  - oACK_TOGGLE is registered, so it changes 3 iCLK cycles after iREQ_TOGGLE.
  - FIFO full: the edge is held pending and not acked. The pending pixel is pushed, and ack toggled, in the first cycle the FIFO is not full at cycle start. Full is judged at cycle start; a same-cycle pop does not free a slot.
  - A second edge while one is pending cannot occur under the protocol (HPS waits for ack); no action required.
- Discard, outside RUN: a req edge is acked (toggle) without a push, so the HPS never hangs. This includes an edge pending at abort time.
- Drain:
  - When the FIFO is non-empty, iWR_READY=1 and state is RUN, pop and assert oWR for one cycle.
  - oWR_DATA is registered with oWR. Minimum latency from push to oWR is 1 cycle.
  - iWR_READY=0 holds the data; no strobe is issued.
- Counters: advance on each oWR. X wraps at H_ACTIVE-1 to 0 and Y increments. The frame ends at the last pixel; X/Y hold their final values until the next LOAD.
- Pixels beyond a frame never reach the FIFO, because the state leaves RUN on the last strobe.
- Reset mid-frame: immediate return to reset state. The ack toggle returns to 0, and HPS software must re-init its toggle to 0.

Test Plan:
- Reset, then iSTART 0->1 -> oWR_LOAD pulses exactly once, 3 cycles after the iSTART edge; oBUSY=1; X=Y=0.
- Push pixel 10'h3FF -> oACK_TOGGLE toggles 3 cycles after req; oWR_DATA=16'h7FFF with oWR one cycle later; X=1.
- iWR_READY=0, push 9 pixels -> 8 acks, 9th ack withheld; raise iWR_READY -> 9th ack follows; 9 strobes in push order.
- Full frame of 307200 pixels with values (i mod 1024) -> exactly 307200 oWR; oFrame_Done single pulse; oFrame_Cont=1; Y wraps correctly at X=639.
- Drop iSTART after 1000 pixels -> state IDLE, oABORT=1, FIFO flushed, no oFrame_Done; later toggles still acked with no oWR.
- Assert iRST during RUN with FIFO half full -> all outputs 0 asynchronously; next start -> clean LOAD, oABORT cleared.
